// File: rtl/test_area_prmter_hls_deadlock_detector_if.sv
// Bundle between the region's idx monitors and the deadlock detector:
// monitor block flags and control in, latched verdict and stall count out.
interface test_area_prmter_hls_deadlock_detector_if #(
  parameter int NUM_MONITORS = 4,
  parameter int CNT_WIDTH    = 16
);
  localparam int IDX_W = (NUM_MONITORS > 1) ? $clog2(NUM_MONITORS) : 1;

  logic [NUM_MONITORS-1:0] block_sigs;
  logic                    all_idle;
  logic                    clear;
  logic                    deadlock_found;
  logic [IDX_W-1:0]        deadlock_idx;
  logic [NUM_MONITORS-1:0] block_snapshot;
  logic [CNT_WIDTH-1:0]    stall_cycles;

  modport master (
    output block_sigs, all_idle, clear,
    input  deadlock_found, deadlock_idx, block_snapshot, stall_cycles
  );

  modport slave (
    input  block_sigs, all_idle, clear,
    output deadlock_found, deadlock_idx, block_snapshot, stall_cycles
  );
endinterface

// File: rtl/test_area_prmter_hls_deadlock_detector.sv
// Declares a dataflow-region deadlock once qualified blocking persists for
// THRESHOLD consecutive cycles; the verdict, culprit and snapshot are sticky.
module test_area_prmter_hls_deadlock_detector #(
  parameter int NUM_MONITORS = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int THRESHOLD    = 1000
) (
  input logic clock,
  input logic reset,
  test_area_prmter_hls_deadlock_detector_if.slave bus
);
  localparam int IDX_W = (NUM_MONITORS > 1) ? $clog2(NUM_MONITORS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DETECTED = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    counter;
  logic                    found_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_MONITORS-1:0] snap_q;
  logic                    blk;
  logic [CNT_WIDTH-1:0]    nxt;

  // Holds at all-ones so a long stall never reads back as a short one.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MONITORS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign blk = (|bus.block_sigs) & ~bus.all_idle;
  assign nxt = sat_inc(counter);

  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      state   <= IDLE;
      counter <= '0;
      found_q <= 1'b0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      case (state)
        IDLE, COUNTING: begin
          if (!blk) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= nxt;
            if (nxt == THR) begin
              state   <= DETECTED;
              found_q <= 1'b1;
              idx_q   <= lowest_idx(bus.block_sigs);
              snap_q  <= bus.block_sigs;
            end else begin
              state <= COUNTING;
            end
          end
        end
        DETECTED: begin
          // Verdict stays latched until clear; only the stall count moves.
          if (blk) counter <= nxt;
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign bus.deadlock_found = found_q;
  assign bus.deadlock_idx   = idx_q;
  assign bus.block_snapshot = snap_q;
  assign bus.stall_cycles   = counter;
endmodule

// File: tb/tb_test_area_prmter_hls_deadlock_detector.sv
// Directed bench for the deadlock detector in three parameterisations:
// THRESHOLD=8, THRESHOLD=1, and a 4-bit counter with THRESHOLD=15.
module tb_test_area_prmter_hls_deadlock_detector;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  test_area_prmter_hls_deadlock_detector_if #(.NUM_MONITORS(4), .CNT_WIDTH(16)) if8 ();
  test_area_prmter_hls_deadlock_detector_if #(.NUM_MONITORS(4), .CNT_WIDTH(16)) if1 ();
  test_area_prmter_hls_deadlock_detector_if #(.NUM_MONITORS(4), .CNT_WIDTH(4))  if4 ();

  test_area_prmter_hls_deadlock_detector #(.NUM_MONITORS(4), .CNT_WIDTH(16), .THRESHOLD(8))
    u_th8 (.clock(clock), .reset(reset), .bus(if8));
  test_area_prmter_hls_deadlock_detector #(.NUM_MONITORS(4), .CNT_WIDTH(16), .THRESHOLD(1))
    u_th1 (.clock(clock), .reset(reset), .bus(if1));
  test_area_prmter_hls_deadlock_detector #(.NUM_MONITORS(4), .CNT_WIDTH(4), .THRESHOLD(15))
    u_sat (.clock(clock), .reset(reset), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check8(input string tag, input int found, input int idx,
                        input int snap, input int stall);
    chk({tag, ".found"}, 32'(if8.deadlock_found), 32'(found));
    chk({tag, ".idx"},   32'(if8.deadlock_idx),   32'(idx));
    chk({tag, ".snap"},  32'(if8.block_snapshot), 32'(snap));
    chk({tag, ".stall"}, 32'(if8.stall_cycles),   32'(stall));
  endtask

  task automatic pulse_clear8();
    if8.clear = 1'b1;
    tick();
    if8.clear = 1'b0;
  endtask

  initial begin
    if8.block_sigs = '0; if8.all_idle = 1'b0; if8.clear = 1'b0;
    if1.block_sigs = '0; if1.all_idle = 1'b0; if1.clear = 1'b0;
    if4.block_sigs = '0; if4.all_idle = 1'b0; if4.clear = 1'b0;

    tick(2);
    reset = 1'b0;
    check8("reset", 0, 0, 0, 0);
    chk("reset.th1.found", 32'(if1.deadlock_found), 0);
    chk("reset.sat.stall", 32'(if4.stall_cycles), 0);

    // Basic detect: counts 1..7, verdict on the 8th blocked edge
    if8.block_sigs = 4'b0100;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("basic.stall%0d", i), 32'(if8.stall_cycles), 32'(i));
      chk($sformatf("basic.found%0d", i), 32'(if8.deadlock_found), 0);
    end
    tick();
    check8("basic.det", 1, 2, 4'b0100, 8);

    // Sticky: unblocked holds verdict and count, reblocked keeps counting
    if8.block_sigs = 4'b0000;
    tick(3);
    check8("sticky.hold", 1, 2, 4'b0100, 8);
    if8.block_sigs = 4'b1000;
    tick();
    check8("sticky.inc", 1, 2, 4'b0100, 9);

    // Clear while blocked: zeroed next cycle, detection again 8 cycles later
    if8.block_sigs = 4'b0100;
    pulse_clear8();
    check8("clear", 0, 0, 0, 0);
    tick(7);
    check8("clear.re7", 0, 0, 0, 7);
    tick();
    check8("clear.re8", 1, 2, 4'b0100, 8);

    // Reset in DETECTED
    reset = 1'b1;
    tick();
    check8("rst.det", 0, 0, 0, 0);
    reset = 1'b0;
    if8.block_sigs = 4'b0000;
    tick();

    // Gap restart
    if8.block_sigs = 4'b0010;
    tick(7);
    check8("gap.pre", 0, 0, 0, 7);
    if8.block_sigs = 4'b0000;
    tick();
    check8("gap.zero", 0, 0, 0, 0);
    if8.block_sigs = 4'b0010;
    tick(7);
    check8("gap.re7", 0, 0, 0, 7);
    tick();
    check8("gap.re8", 1, 1, 4'b0010, 8);

    // Idle masking, then alternating bits keep one uninterrupted count
    pulse_clear8();
    if8.block_sigs = 4'b0011;
    if8.all_idle = 1'b1;
    tick(20);
    check8("idle", 0, 0, 0, 0);
    if8.all_idle = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if8.block_sigs = (k % 2 == 1) ? 4'b0001 : 4'b1000;
      tick();
      if (k == 4) check8("alt.mid", 0, 0, 0, 4);
    end
    check8("alt.det", 1, 3, 4'b1000, 8);

    // Reset in COUNTING
    pulse_clear8();
    if8.block_sigs = 4'b0100;
    tick(3);
    chk("rst.cnt.pre", 32'(if8.stall_cycles), 3);
    reset = 1'b1;
    tick();
    check8("rst.cnt", 0, 0, 0, 0);
    reset = 1'b0;
    if8.block_sigs = 4'b0000;

    // THRESHOLD=1: verdict on the first blocked edge
    if1.block_sigs = 4'b0010;
    tick();
    chk("th1.found", 32'(if1.deadlock_found), 1);
    chk("th1.idx",   32'(if1.deadlock_idx),   1);
    chk("th1.snap",  32'(if1.block_snapshot), 32'(4'b0010));
    chk("th1.stall", 32'(if1.stall_cycles),   1);
    if1.block_sigs = 4'b0000;

    // 4-bit counter saturates at 15 and never wraps
    if4.block_sigs = 4'b0001;
    tick(14);
    chk("sat.found14", 32'(if4.deadlock_found), 0);
    chk("sat.stall14", 32'(if4.stall_cycles), 14);
    tick();
    chk("sat.found15", 32'(if4.deadlock_found), 1);
    chk("sat.stall15", 32'(if4.stall_cycles), 15);
    tick(25);
    chk("sat.found40", 32'(if4.deadlock_found), 1);
    chk("sat.stall40", 32'(if4.stall_cycles), 15);
    chk("sat.idx",     32'(if4.deadlock_idx), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/test_area_prmter_hls_deadlock_detector.md
# test_area_prmter_hls_deadlock_detector

Aggregates the per-process deadlock monitor `block` outputs of the Test_area_prmter dataflow region (AXIvideo2xfMat, processing, xfMat2AXIvideo stages) and decides whether the region is deadlocked. It sits directly downstream of the idx monitors. A deadlock is declared only when blocking persists for a programmable number of consecutive cycles while the region is not idle. The decision is latched together with the culprit index and a snapshot of the block vector, so firmware or ILA can read them.

## Interface
- `NUM_MONITORS`, 4: number of monitor `block` inputs; 1..32.
- `CNT_WIDTH`, 16: width of the persistence/stall counter.
- `THRESHOLD`, 1000: consecutive blocked cycles required to declare deadlock; 1 ≤ THRESHOLD ≤ 2^CNT_WIDTH−1.
- Local `IDX_W` = max(1, clog2(NUM_MONITORS)).

Ports:
- `clock`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `block_sigs`, in, NUM_MONITORS: bit i = `block` of monitor i, already registered by the monitor.
- `all_idle`, in, 1: whole region idle; suppresses detection.
- `clear`, in, 1: single-cycle pulse; releases a latched detection.
- `deadlock_found`, out, 1: sticky deadlock flag.
- `deadlock_idx`, out, IDX_W: lowest set index of `block_sigs` in the detection cycle.
- `block_snapshot`, out, NUM_MONITORS: `block_sigs` captured in the detection cycle.
- `stall_cycles`, out, CNT_WIDTH: current consecutive blocked-cycle count, saturating.

## Operation
- Qualified block: `blk = (|block_sigs) & ~all_idle`.
- FSM states:
  - **IDLE**, counter = 0.
  - **COUNTING**.
  - **DETECTED**.
- Next count: `nxt = counter + 1`, saturating at 2^CNT_WIDTH−1.
- IDLE transitions:
  - `blk` and `nxt == THRESHOLD` → DETECTED. This applies when THRESHOLD = 1.
  - Otherwise `blk` → COUNTING, counter = 1.
  - `!blk` → stay in IDLE.
- COUNTING transitions:
  - `!blk` → IDLE, counter = 0.
  - `blk` and `nxt == THRESHOLD` → DETECTED, counter = nxt.
  - Otherwise counter = nxt.
  - Changes in which bits are set do not restart the count; only all-clear or `all_idle` does.
- Entering DETECTED: in the same edge, `deadlock_found`←1, `deadlock_idx`←lowest set bit of `block_sigs`, `block_snapshot`←`block_sigs`.
- DETECTED behaviour:
  - Outputs are frozen, except `stall_cycles`.
  - `stall_cycles` increments (saturating) while `blk`, and holds while `!blk`.
  - The state does not leave on `!blk`.
- `clear` priority:
  - `clear` overrides every transition except `reset`.
  - Any state → IDLE with counter, `deadlock_found`, `deadlock_idx` and `block_snapshot` all zeroed.
  - `blk` is ignored in the `clear` cycle. Re-counting starts on the next cycle.
- `stall_cycles` = counter register in all states.

## Timing
- Reset values: `deadlock_found`=0, `deadlock_idx`=0, `block_snapshot`=0, `stall_cycles`=0, state IDLE.
- All outputs are registered; no combinational input→output paths.
- Detection latency: if `blk` is first high at cycle c and stays high, `deadlock_found` is high from cycle c+THRESHOLD. It samples as 1 after the edge ending cycle c+THRESHOLD−1.
- A one-cycle gap in `blk` at any point before detection resets the counter. The full THRESHOLD must elapse again.
- `all_idle` high has the same effect as `block_sigs`==0.
- Reset asserted mid-count or in DETECTED: everything returns to reset values at that edge.
- Saturation: the counter holds at all-ones and never wraps to 0.

## Test plan
- Setup: THRESHOLD=8, NUM_MONITORS=4 unless stated.
- **Basic detect:** `block_sigs`=4'b0100 held from cycle 10 → `stall_cycles` 1..7 on cycles 11..17; at cycle 18 `deadlock_found`=1, `deadlock_idx`=2, `block_snapshot`=4'b0100.
- **Gap restart:** block 7 cycles, 0 for 1 cycle, then block again → no detect until 8 further blocked cycles; counter returns to 0 in the gap.
- **Idle masking and bit changes:** `block_sigs`=4'b0011 with `all_idle`=1 for 20 cycles → `stall_cycles` stays 0, no detect. Then with `all_idle`=0, vector alternates 4'b0001/4'b1000 each cycle → count uninterrupted; detect with `deadlock_idx` equal to the lowest set bit in the 8th cycle.
- **Sticky and clear:**
  - After detect, drop `block_sigs` → `deadlock_found` stays 1 and `stall_cycles` holds.
  - Pulse `clear` while blocked → all outputs 0 next cycle; detection recurs 8 blocked cycles after `clear`.
- **Boundaries:**
  - THRESHOLD=1: first blocked cycle → `deadlock_found`=1 at the next edge.
  - CNT_WIDTH=4, THRESHOLD=15, blocked 40 cycles → `stall_cycles` saturates at 15, no wrap.
  - Reset asserted in COUNTING and in DETECTED → all outputs 0 on the next edge.
